hdmi_clk_meter: RTL and testbench



---
 rtl/hdmi_clk_meter.sv | 154 +++++++++++++++
 tb/tb_hdmi_clk_meter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_clk_meter.sv
// Clock-domain consumer of the HDMI receiver clock-measurement toggle handshake.
// Publishes one pixel-clocks-per-gate count per gate period with validity, saturation and timeout status.
module hdmi_clk_meter #(
    parameter int CLK_CTR_MAX   = 27,
    parameter int GATE_CYCLES   = 50000000,
    parameter int SETTLE_CYCLES = 8,
    parameter int ERR_CTR_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   pll_locked__clk,
    output logic                   clk_ctr_reset_req__clk,
    input  logic                   clk_ctr_reset_ack__clk,
    input  logic [CLK_CTR_MAX:0]   clk_ctr_at_reset__clk,
    output logic [CLK_CTR_MAX:0]   freq_count,
    output logic                   freq_valid,
    output logic                   freq_sat,
    output logic                   freq_update,
    output logic                   err_timeout,
    output logic [ERR_CTR_W-1:0]   err_count
);

    localparam int PER_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [PER_W-1:0]     PER_LAST = PER_W'(GATE_CYCLES - 1);
    localparam logic [PER_W-1:0]     PER_ONE  = PER_W'(1);
    localparam logic [SET_W-1:0]     SET_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SET_W-1:0]     SET_ONE  = SET_W'(1);
    localparam logic [ERR_CTR_W-1:0] ERR_ONE  = ERR_CTR_W'(1);
    localparam logic [ERR_CTR_W-1:0] ERR_MAX  = '1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_ACK = 2'd1;
    localparam logic [1:0] S_SETTLE   = 2'd2;
    localparam logic [1:0] S_CAPTURE  = 2'd3;

    logic [1:0]             r_state;
    logic [PER_W-1:0]       r_period;
    logic [SET_W-1:0]       r_settle;
    logic                   r_req;
    logic                   r_discard;
    logic                   r_lock_lost;
    logic                   r_enable_d;
    logic                   r_locked_d;
    logic [CLK_CTR_MAX:0]   r_freq_count;
    logic                   r_freq_valid;
    logic                   r_freq_sat;
    logic                   r_freq_update;
    logic                   r_err_timeout;
    logic [ERR_CTR_W-1:0]   r_err_count;

    logic w_gate;
    logic w_capture;
    logic w_timeout;
    logic w_sat;
    logic w_set_discard;

    // A gate edge landing on the CAPTURE cycle is not a timeout: that capture still completes.
    assign w_gate        = enable & (r_period == PER_LAST);
    assign w_capture     = (r_state == S_CAPTURE);
    assign w_timeout     = w_gate & (r_state != S_IDLE) & ~w_capture;
    assign w_sat         = &clk_ctr_at_reset__clk;
    assign w_set_discard = w_timeout | (enable & ~r_enable_d) | (pll_locked__clk & ~r_locked_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_period      <= '0;
            r_settle      <= '0;
            r_req         <= 1'b0;
            r_discard     <= 1'b1;
            r_lock_lost   <= 1'b0;
            r_enable_d    <= 1'b0;
            r_locked_d    <= 1'b0;
            r_freq_count  <= '0;
            r_freq_valid  <= 1'b0;
            r_freq_sat    <= 1'b0;
            r_freq_update <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_freq_update <= 1'b0;
            r_err_timeout <= 1'b0;
            r_enable_d    <= enable;
            r_locked_d    <= pll_locked__clk;

            if (!enable || r_period == PER_LAST) begin
                r_period <= '0;
            end else begin
                r_period <= r_period + PER_ONE;
            end

            case (r_state)
                S_WAIT_ACK: begin
                    if (clk_ctr_reset_ack__clk == r_req) begin
                        r_state  <= S_SETTLE;
                        r_settle <= SET_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (r_settle == '0) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_settle <= r_settle - SET_ONE;
                    end
                end
                S_CAPTURE: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase

            // Validity must see lock_lost/discard as they were for the window being captured.
            if (w_capture) begin
                r_freq_count  <= clk_ctr_at_reset__clk;
                r_freq_sat    <= w_sat;
                r_freq_valid  <= ~r_discard & ~r_lock_lost & ~w_sat & pll_locked__clk;
                r_freq_update <= 1'b1;
            end

            if (w_gate) begin
                r_req       <= ~r_req;
                r_lock_lost <= ~pll_locked__clk;
                r_state     <= S_WAIT_ACK;
            end else if (!pll_locked__clk) begin
                r_lock_lost <= 1'b1;
            end

            if (w_timeout) begin
                r_err_timeout <= 1'b1;
                r_freq_valid  <= 1'b0;
                r_freq_update <= 1'b1;
                if (r_err_count != ERR_MAX) begin
                    r_err_count <= r_err_count + ERR_ONE;
                end
            end

            if (w_set_discard) begin
                r_discard <= 1'b1;
            end else if (w_capture) begin
                r_discard <= 1'b0;
            end
        end
    end

    assign clk_ctr_reset_req__clk = r_req;
    assign freq_count             = r_freq_count;
    assign freq_valid             = r_freq_valid;
    assign freq_sat               = r_freq_sat;
    assign freq_update            = r_freq_update;
    assign err_timeout            = r_err_timeout;
    assign err_count              = r_err_count;

endmodule

// File: tb/tb_hdmi_clk_meter.sv
// Bench for hdmi_clk_meter: receiver model echoes req as ack, reference model predicts each publication.
module tb_hdmi_clk_meter;

    localparam int CLK_CTR_MAX   = 27;
    localparam int GATE_CYCLES   = 100;
    localparam int SETTLE_CYCLES = 4;
    localparam int ERR_CTR_W     = 8;
    localparam int W             = CLK_CTR_MAX + 1;
    localparam int VW            = 4 + ERR_CTR_W + W + 1;
    localparam logic [W-1:0]         ALL_ONES = '1;
    localparam logic [ERR_CTR_W-1:0] ERR_MAX  = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic lock = 1'b0;
    logic ack;
    logic req;
    logic [W-1:0] rxCount = '0;
    logic [W-1:0] freqCount;
    logic freqValid, freqSat, freqUpdate, errTimeout;
    logic [ERR_CTR_W-1:0] errCount;

    logic [3:0] ackChain = '0;
    logic suppressAck = 1'b0;

    int checks = 0;
    int failures = 0;

    hdmi_clk_meter #(
        .CLK_CTR_MAX  (CLK_CTR_MAX),
        .GATE_CYCLES  (GATE_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .ERR_CTR_W    (ERR_CTR_W)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .enable                (enable),
        .pll_locked__clk       (lock),
        .clk_ctr_reset_req__clk(req),
        .clk_ctr_reset_ack__clk(ack),
        .clk_ctr_at_reset__clk (rxCount),
        .freq_count            (freqCount),
        .freq_valid            (freqValid),
        .freq_sat              (freqSat),
        .freq_update           (freqUpdate),
        .err_timeout           (errTimeout),
        .err_count             (errCount)
    );

    always #5 clk = ~clk;

    // Receiver: ack follows req through four flops, so the meter sees it 5 clk after a toggle.
    assign ack = ackChain[3];
    always @(posedge clk) begin
        ackChain <= {ackChain[2:0], suppressAck ? ackChain[0] : req};
    end

    // Reference model: a toggle is published SETTLE_CYCLES+1 clk after the ack matches it.
    logic expReq, expUpdate, expTimeout, expValid, expSat;
    logic [W-1:0] expCount;
    logic [ERR_CTR_W-1:0] expErrCount;
    int tbCyc = 0;
    int mPeriod, mPublishAt;
    bit mWaiting, mDiscard, mLockLost, mLastEn, mLastLock;
    bit mGate, mBusy, mPublishNow, mNewDiscard;

    always @(posedge clk) begin
        tbCyc++;
        if (rst) begin
            mPeriod = 0; mPublishAt = -1; mWaiting = 0; mDiscard = 1; mLockLost = 0;
            mLastEn = 0; mLastLock = 0;
            expReq = 0; expUpdate = 0; expTimeout = 0; expValid = 0; expSat = 0;
            expCount = '0; expErrCount = '0;
        end else begin
            expUpdate = 0;
            expTimeout = 0;
            mGate = enable && (mPeriod == GATE_CYCLES - 1);
            mPublishNow = (mPublishAt == tbCyc);
            mBusy = mWaiting || (mPublishAt >= 0 && !mPublishNow);
            mNewDiscard = mDiscard;
            if (mPublishNow) begin
                expCount = rxCount;
                expSat = (rxCount == ALL_ONES);
                expValid = !mDiscard && !mLockLost && !expSat && lock;
                expUpdate = 1;
                mNewDiscard = 0;
                mPublishAt = -1;
            end
            if (mWaiting && ack == expReq) begin
                mWaiting = 0;
                mPublishAt = tbCyc + SETTLE_CYCLES + 1;
            end
            if (mGate) begin
                if (mBusy) begin
                    expTimeout = 1;
                    if (expErrCount != ERR_MAX) expErrCount = expErrCount + 1'b1;
                    expValid = 0;
                    expUpdate = 1;
                    mNewDiscard = 1;
                end
                expReq = ~expReq;
                mLockLost = !lock;
                mWaiting = 1;
                mPublishAt = -1;
            end else if (!lock) begin
                mLockLost = 1;
            end
            if ((enable && !mLastEn) || (lock && !mLastLock)) mNewDiscard = 1;
            mDiscard = mNewDiscard;
            mLastEn = enable;
            mLastLock = lock;
            mPeriod = enable ? ((mPeriod == GATE_CYCLES - 1) ? 0 : mPeriod + 1) : 0;
        end
    end

    wire [VW-1:0] dutVec = {req, freqUpdate, errTimeout, freqValid, freqSat, errCount, freqCount};
    wire [VW-1:0] expVec = {expReq, expUpdate, expTimeout, expValid, expSat, expErrCount, expCount};

    task automatic doReset(input logic [W-1:0] count);
        @(negedge clk);
        rst = 1; enable = 1; lock = 1; rxCount = count;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic waitUpdate(input int budget, output bit seen, output int when);
        seen = 0;
        when = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (freqUpdate || expUpdate) begin
                seen = 1;
                when = tbCyc;
                break;
            end
        end
    endtask

    task automatic waitToggle(input int budget, output bit seen, output int when);
        logic startReq;
        startReq = req;
        seen = 0;
        when = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req !== startReq) begin
                seen = 1;
                when = tbCyc;
                break;
            end
        end
    endtask

    function automatic logic [W-1:0] randCount();
        return W'($urandom_range(0, 32'h0FFF_FFFE));
    endfunction

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (dutVec !== {VW{1'b0}}) begin
            failures++;
            $display("[TB] FAIL reset_zero: got %h expected %h", dutVec, {VW{1'b0}});
        end
        checks++;
        if (dutVec !== expVec) begin
            failures++;
            $display("[TB] FAIL reset_model: got %h expected %h", dutVec, expVec);
        end
    endtask

    task automatic test_basic;
        bit seen;
        int tToggle, tUpd, tPrev;
        doReset(W'(400));
        waitToggle(150, seen, tToggle);
        checks++;
        if (!seen) begin failures++; $display("[TB] FAIL basic_toggle: got none expected toggle"); end
        waitUpdate(30, seen, tUpd);
        checks++;
        if (!seen || tUpd - tToggle != 10) begin
            failures++;
            $display("[TB] FAIL basic_latency: got %0d expected 10", tUpd - tToggle);
        end
        checks++;
        if (freqValid !== 1'b0 || freqUpdate !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_first_discard: got valid=%0b update=%0b expected valid=0 update=1", freqValid, freqUpdate);
        end
        tPrev = tUpd;
        for (int n = 0; n < 4; n++) begin
            waitUpdate(150, seen, tUpd);
            checks++;
            if (!seen || tUpd - tPrev != GATE_CYCLES) begin
                failures++;
                $display("[TB] FAIL basic_interval: got %0d expected %0d", tUpd - tPrev, GATE_CYCLES);
            end
            checks++;
            if (freqValid !== 1'b1 || freqCount !== rxCount) begin
                failures++;
                $display("[TB] FAIL basic_count: got %h/%0b expected %h/1", freqCount, freqValid, rxCount);
            end
            checks++;
            if (dutVec !== expVec) begin
                failures++;
                $display("[TB] FAIL basic_model: got %h expected %h", dutVec, expVec);
            end
            tPrev = tUpd;
            rxCount = randCount();
        end
    endtask

    task automatic test_timeout;
        bit seen;
        int tToggle, tUpd;
        doReset(randCount());
        repeat (2) waitUpdate(150, seen, tUpd);
        waitToggle(150, seen, tToggle);
        suppressAck = 1;
        waitUpdate(150, seen, tUpd);
        checks++;
        if (!seen || tUpd - tToggle != GATE_CYCLES) begin
            failures++;
            $display("[TB] FAIL timeout_time: got %0d expected %0d", tUpd - tToggle, GATE_CYCLES);
        end
        checks++;
        if (errTimeout !== 1'b1 || errCount !== ERR_CTR_W'(1) || freqValid !== 1'b0 || freqUpdate !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_flags: got tmo=%0b cnt=%0d valid=%0b upd=%0b expected 1 1 0 1",
                     errTimeout, errCount, freqValid, freqUpdate);
        end
        checks++;
        if (dutVec !== expVec) begin
            failures++;
            $display("[TB] FAIL timeout_model: got %h expected %h", dutVec, expVec);
        end
        suppressAck = 0;
        for (int n = 0; n < 2; n++) begin
            waitUpdate(150, seen, tUpd);
            checks++;
            if (!seen || freqValid !== logic'(n == 1) || freqUpdate !== 1'b1) begin
                failures++;
                $display("[TB] FAIL timeout_recover%0d: got valid=%0b expected %0d", n, freqValid, n);
            end
            checks++;
            if (dutVec !== expVec) begin
                failures++;
                $display("[TB] FAIL timeout_recover_model%0d: got %h expected %h", n, dutVec, expVec);
            end
        end
    endtask

    task automatic test_lock_glitch;
        bit seen;
        int tUpd;
        repeat ($urandom_range(10, 70)) @(negedge clk);
        lock = 0;
        @(negedge clk);
        lock = 1;
        for (int n = 0; n < 2; n++) begin
            waitUpdate(150, seen, tUpd);
            checks++;
            if (!seen || freqValid !== logic'(n == 1)) begin
                failures++;
                $display("[TB] FAIL lock_valid%0d: got %0b expected %0d", n, freqValid, n);
            end
            checks++;
            if (dutVec !== expVec) begin
                failures++;
                $display("[TB] FAIL lock_model%0d: got %h expected %h", n, dutVec, expVec);
            end
        end
    endtask

    task automatic test_saturation;
        bit seen;
        int tUpd;
        rxCount = ALL_ONES;
        waitUpdate(150, seen, tUpd);
        checks++;
        if (!seen || freqCount !== ALL_ONES || freqSat !== 1'b1 || freqValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_flags: got %h sat=%0b valid=%0b expected %h 1 0", freqCount, freqSat, freqValid, ALL_ONES);
        end
        checks++;
        if (dutVec !== expVec) begin
            failures++;
            $display("[TB] FAIL sat_model: got %h expected %h", dutVec, expVec);
        end
        rxCount = randCount();
        waitUpdate(150, seen, tUpd);
        checks++;
        if (!seen || freqSat !== 1'b0 || freqValid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_clear: got sat=%0b valid=%0b expected 0 1", freqSat, freqValid);
        end
    endtask

    task automatic test_enable_drop;
        bit seen, moved, pulsed;
        int tToggle, tUpd;
        logic reqHold;
        waitToggle(150, seen, tToggle);
        repeat ($urandom_range(5, 8)) @(negedge clk);
        enable = 0;
        waitUpdate(30, seen, tUpd);
        checks++;
        if (!seen || tUpd - tToggle != 10 || freqValid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL endrop_pending: got dt=%0d valid=%0b expected 10 1", tUpd - tToggle, freqValid);
        end
        checks++;
        if (dutVec !== expVec) begin
            failures++;
            $display("[TB] FAIL endrop_model: got %h expected %h", dutVec, expVec);
        end
        reqHold = req;
        moved = 0;
        pulsed = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req !== reqHold) moved = 1;
            if (freqUpdate !== 1'b0) pulsed = 1;
        end
        checks++;
        if (moved || pulsed) begin
            failures++;
            $display("[TB] FAIL endrop_idle: got toggled=%0b updated=%0b expected 0 0", moved, pulsed);
        end
        enable = 1;
        for (int n = 0; n < 2; n++) begin
            waitUpdate(150, seen, tUpd);
            checks++;
            if (!seen || freqValid !== logic'(n == 1)) begin
                failures++;
                $display("[TB] FAIL endrop_reenable%0d: got %0b expected %0d", n, freqValid, n);
            end
            checks++;
            if (dutVec !== expVec) begin
                failures++;
                $display("[TB] FAIL endrop_reenable_model%0d: got %h expected %h", n, dutVec, expVec);
            end
        end
    endtask

    task automatic test_reset_in_wait_ack;
        bit seen;
        int tToggle, tUpd;
        waitToggle(150, seen, tToggle);
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        checks++;
        if (dutVec !== {VW{1'b0}}) begin
            failures++;
            $display("[TB] FAIL midrst_zero: got %h expected %h", dutVec, {VW{1'b0}});
        end
        rst = 0;
        rxCount = randCount();
        for (int n = 0; n < 2; n++) begin
            waitUpdate(150, seen, tUpd);
            checks++;
            if (!seen || freqValid !== logic'(n == 1)) begin
                failures++;
                $display("[TB] FAIL midrst_valid%0d: got %0b expected %0d", n, freqValid, n);
            end
            checks++;
            if (dutVec !== expVec) begin
                failures++;
                $display("[TB] FAIL midrst_model%0d: got %h expected %h", n, dutVec, expVec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_lock_glitch();
        test_saturation();
        test_enable_drop();
        test_reset_in_wait_ack();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
